// File: rtl/flash_cache_if.sv
// Bus bundle between the Wishbone flash front end, the cache and the SPI flash line-fill streamer.
// The slave view is the cache; the master view is everything around it.
interface flash_cache_if;
  logic        flashCache_readEnable;
  logic [23:0] flashCache_address;
  logic [3:0]  flashCache_byteSelect;
  logic [31:0] flashCache_dataRead;
  logic        flashCache_busy;
  logic        cache_invalidate;
  logic        flash_requestLoad;
  logic [23:0] flash_loadAddress;
  logic        flash_wordValid;
  logic [31:0] flash_wordData;

  modport slave (
    input  flashCache_readEnable, flashCache_address, flashCache_byteSelect,
    input  cache_invalidate, flash_wordValid, flash_wordData,
    output flashCache_dataRead, flashCache_busy, flash_requestLoad, flash_loadAddress
  );

  modport master (
    output flashCache_readEnable, flashCache_address, flashCache_byteSelect,
    output cache_invalidate, flash_wordValid, flash_wordData,
    input  flashCache_dataRead, flashCache_busy, flash_requestLoad, flash_loadAddress
  );
endinterface

// File: rtl/flash_cache.sv
// Direct-mapped read-only flip-flop cache in front of the SPI flash; hits are combinational,
// misses stall with busy while the line streams in word by word.
module flash_cache #(
  parameter int LINE_WORDS_LOG2 = 3,
  parameter int LINES_LOG2      = 2
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  flash_cache_if.slave bus
);
  localparam int LINE_WORDS = 1 << LINE_WORDS_LOG2;
  localparam int LINES      = 1 << LINES_LOG2;
  localparam int IDX_LSB    = 2 + LINE_WORDS_LOG2;
  localparam int TAG_LSB    = IDX_LSB + LINES_LOG2;
  localparam int TAG_W      = 24 - TAG_LSB;

  typedef enum logic {IDLE, FILL} state_t;

  state_t state, state_next;

  logic [31:0]                line_data [LINES][LINE_WORDS];
  logic [TAG_W-1:0]           tag_mem   [LINES];
  logic [LINES-1:0]           valid;
  logic [LINE_WORDS_LOG2-1:0] counter;
  logic [LINES_LOG2-1:0]      fill_index;
  logic [TAG_W-1:0]           fill_tag;
  logic                       pending;

  logic [LINE_WORDS_LOG2-1:0] req_offset;
  logic [LINES_LOG2-1:0]      req_index;
  logic [TAG_W-1:0]           req_tag;
  logic                       hit, start_fill, word_accept, fill_done;
  logic [31:0]                byte_mask;
  logic                       addr_unused;

  assign req_offset  = bus.flashCache_address[2 +: LINE_WORDS_LOG2];
  assign req_index   = bus.flashCache_address[IDX_LSB +: LINES_LOG2];
  assign req_tag     = bus.flashCache_address[23:TAG_LSB];
  assign addr_unused = ^bus.flashCache_address[1:0];

  assign hit         = (state == IDLE) && valid[req_index] && (tag_mem[req_index] == req_tag);
  assign start_fill  = (state == IDLE) && bus.flashCache_readEnable && !hit;
  assign word_accept = (state == FILL) && bus.flash_wordValid;
  assign fill_done   = word_accept && (counter == LINE_WORDS_LOG2'(LINE_WORDS - 1));

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < 4; b++) byte_mask[8*b +: 8] = {8{bus.flashCache_byteSelect[b]}};
  end

  assign bus.flashCache_dataRead = (bus.flashCache_readEnable && hit)
                                   ? (line_data[req_index][req_offset] & byte_mask) : '0;
  assign bus.flashCache_busy     = bus.flashCache_readEnable && !hit;
  assign bus.flash_requestLoad   = (state == FILL);
  assign bus.flash_loadAddress   = (state == FILL)
                                   ? {fill_tag, fill_index, {LINE_WORDS_LOG2{1'b0}}, 2'b00} : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_fill) state_next = FILL;
      FILL:    if (fill_done)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Later assignments win: an invalidate on the final word leaves the new line invalid too.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      valid      <= '0;
      counter    <= '0;
      pending    <= 1'b0;
      fill_index <= '0;
      fill_tag   <= '0;
    end else begin
      if (start_fill) begin
        valid[req_index] <= 1'b0;
        counter          <= '0;
        fill_index       <= req_index;
        fill_tag         <= req_tag;
      end
      if (word_accept) counter <= counter + LINE_WORDS_LOG2'(1);
      if (fill_done) begin
        valid[fill_index] <= ~(pending | bus.cache_invalidate);
        pending           <= 1'b0;
      end
      if (bus.cache_invalidate) begin
        valid <= '0;
        if ((state == FILL) && !fill_done) pending <= 1'b1;
      end
    end
  end

  // NOTE: data and tag storage carry no reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge wb_clk_i) begin
    if (word_accept) line_data[fill_index][counter] <= bus.flash_wordData;
    if (fill_done)   tag_mem[fill_index]            <= fill_tag;
  end
endmodule
